layers_readout_arbiter: RTL and testbench

//  Parametrised N-layer interrupt scheduler between the AstroPix layer interrupt pins and the shared

---
 rtl/layers_readout_arbiter_if.sv | 23 ++
 rtl/layers_readout_arbiter.sv | 170 +++++++++++++++++
 tb/tb_layers_readout_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/layers_readout_arbiter_if.sv
// Grant handshake between the layer interrupt arbiter (master) and the shared layer SPI readout engine (slave).
interface layers_readout_arbiter_if #(
  parameter int unsigned IDX_WIDTH = 2
);
  logic                 readout_req;
  logic [IDX_WIDTH-1:0] readout_layer;
  logic                 readout_ack;
  logic                 readout_done;

  modport master (
    output readout_req,
    output readout_layer,
    input  readout_ack,
    input  readout_done
  );

  modport slave (
    input  readout_req,
    input  readout_layer,
    output readout_ack,
    output readout_done
  );
endinterface

// File: rtl/layers_readout_arbiter.sv
// N-layer interrupt scheduler: synchronises and masks AstroPix layer interrupts, grants the shared
// readout engine round-robin, and aborts a grant that overruns its timeout.
module layers_readout_arbiter #(
  parameter int unsigned LAYER_COUNT    = 3,
  parameter int unsigned IDX_WIDTH      = (LAYER_COUNT > 1) ? $clog2(LAYER_COUNT) : 1,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned HOLDOFF_CYCLES = 4
) (
  input  logic                     sysclk,
  input  logic                     resn,
  input  logic [LAYER_COUNT-1:0]   layer_interruptn,
  input  logic [LAYER_COUNT-1:0]   layer_enable,
  layers_readout_arbiter_if.master rd,
  output logic                     readout_abort,
  output logic [LAYER_COUNT-1:0]   layer_hold,
  output logic [LAYER_COUNT-1:0]   pending,
  output logic                     busy,
  output logic [15:0]              timeout_count
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned HC_W  = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [HC_W-1:0]  HC_LAST  = HC_W'(HOLDOFF_CYCLES - 1);
  localparam logic [15:0]      CNT_MAX  = 16'hFFFF;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_ACTIVE  = 2'd2;
  localparam logic [1:0] ST_HOLDOFF = 2'd3;

  logic [1:0]             state_q,  state_d;
  logic [LAYER_COUNT-1:0] sync_q;
  logic [LAYER_COUNT-1:0] pending_q;
  logic                   req_q,    req_d;
  logic [IDX_WIDTH-1:0]   layer_q,  layer_d;
  logic [IDX_WIDTH-1:0]   rr_q,     rr_d;
  logic [LAYER_COUNT-1:0] hold_q,   hold_d;
  logic                   abort_q,  abort_d;
  logic [TMR_W-1:0]       timer_q,  timer_d;
  logic [HC_W-1:0]        hcnt_q,   hcnt_d;
  logic [15:0]            tcount_q, tcount_d;
  logic                   busy_q;

  logic                   sel_found;
  logic [IDX_WIDTH-1:0]   sel_idx;
  int unsigned            cand;

  // First stage catches the asynchronous pins; the second stage folds in the enable mask.
  always_ff @(posedge sysclk) begin
    if (!resn) begin
      sync_q    <= '1;
      pending_q <= '0;
    end else begin
      sync_q    <= layer_interruptn;
      pending_q <= ~sync_q & layer_enable;
    end
  end

  // Round-robin pick: first pending layer after the last grant, wrapping mod LAYER_COUNT.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = rr_q;
    cand      = 0;
    for (int unsigned k = 1; k <= LAYER_COUNT; k++) begin
      cand = (32'(rr_q) + k) % LAYER_COUNT;
      if (!sel_found && pending_q[IDX_WIDTH'(cand)]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_WIDTH'(cand);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    layer_d  = layer_q;
    rr_d     = rr_q;
    hold_d   = hold_q;
    abort_d  = 1'b0;
    timer_d  = timer_q;
    hcnt_d   = hcnt_q;
    tcount_d = tcount_q;

    case (state_q)
      ST_IDLE: begin
        if (sel_found) begin
          layer_d = sel_idx;
          rr_d    = sel_idx;
          req_d   = 1'b1;
          state_d = ST_REQ;
        end
      end

      // The request is never retracted once raised, whatever happens to the interrupt or mask.
      ST_REQ: begin
        if (rd.readout_ack) begin
          req_d   = 1'b0;
          hold_d  = LAYER_COUNT'(1) << layer_q;
          timer_d = '0;
          state_d = ST_ACTIVE;
        end
      end

      ST_ACTIVE: begin
        timer_d = timer_q + TMR_W'(1);
        if (rd.readout_done) begin
          hold_d  = '0;
          hcnt_d  = '0;
          state_d = ST_HOLDOFF;
        end else if (timer_q == TMR_LAST) begin
          abort_d = 1'b1;
          if (tcount_q != CNT_MAX) begin
            tcount_d = tcount_q + 16'd1;
          end
          hold_d  = '0;
          hcnt_d  = '0;
          state_d = ST_HOLDOFF;
        end
      end

      ST_HOLDOFF: begin
        if (hcnt_q == HC_LAST) begin
          state_d = ST_IDLE;
        end else begin
          hcnt_d = hcnt_q + HC_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // rr_q resets to the last layer so that layer 0 is the first one searched.
  always_ff @(posedge sysclk) begin
    if (!resn) begin
      state_q  <= ST_IDLE;
      req_q    <= 1'b0;
      layer_q  <= '0;
      rr_q     <= IDX_WIDTH'(LAYER_COUNT - 1);
      hold_q   <= '0;
      abort_q  <= 1'b0;
      timer_q  <= '0;
      hcnt_q   <= '0;
      tcount_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      layer_q  <= layer_d;
      rr_q     <= rr_d;
      hold_q   <= hold_d;
      abort_q  <= abort_d;
      timer_q  <= timer_d;
      hcnt_q   <= hcnt_d;
      tcount_q <= tcount_d;
      busy_q   <= (state_d != ST_IDLE);
    end
  end

  assign rd.readout_req   = req_q;
  assign rd.readout_layer = layer_q;
  assign readout_abort    = abort_q;
  assign layer_hold       = hold_q;
  assign pending          = pending_q;
  assign busy             = busy_q;
  assign timeout_count    = tcount_q;

endmodule

// File: tb/tb_layers_readout_arbiter.sv
// Directed bench for layers_readout_arbiter: a 3-layer instance driven from a cycle table and
// hand sequences, plus 5-layer and 1-layer instances for wrap-around and degenerate arbitration.
module tb_layers_readout_arbiter;

  logic        sysclk;
  logic        resn, resn5, resn1;
  logic [2:0]  intn3, en3, hold3, pend3;
  logic        abort3, busy3;
  logic [15:0] tcnt3;
  logic [4:0]  intn5, en5, hold5, pend5;
  logic        abort5, busy5;
  logic [15:0] tcnt5;
  logic [0:0]  intn1, en1, hold1, pend1;
  logic        abort1, busy1;
  logic [15:0] tcnt1;

  int n_checks;
  int n_fail;

  layers_readout_arbiter_if #(.IDX_WIDTH(2)) rd3 ();
  layers_readout_arbiter_if #(.IDX_WIDTH(3)) rd5 ();
  layers_readout_arbiter_if #(.IDX_WIDTH(1)) rd1 ();

  layers_readout_arbiter #(.LAYER_COUNT(3)) u_dut3 (
    .sysclk(sysclk), .resn(resn), .layer_interruptn(intn3), .layer_enable(en3), .rd(rd3),
    .readout_abort(abort3), .layer_hold(hold3), .pending(pend3), .busy(busy3), .timeout_count(tcnt3));

  layers_readout_arbiter #(.LAYER_COUNT(5)) u_dut5 (
    .sysclk(sysclk), .resn(resn5), .layer_interruptn(intn5), .layer_enable(en5), .rd(rd5),
    .readout_abort(abort5), .layer_hold(hold5), .pending(pend5), .busy(busy5), .timeout_count(tcnt5));

  layers_readout_arbiter #(.LAYER_COUNT(1)) u_dut1 (
    .sysclk(sysclk), .resn(resn1), .layer_interruptn(intn1), .layer_enable(en1), .rd(rd1),
    .readout_abort(abort1), .layer_hold(hold1), .pending(pend1), .busy(busy1), .timeout_count(tcnt1));

  initial begin
    sysclk = 1'b0;
    forever #5 sysclk = ~sysclk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic       resn;
    logic [2:0] intn;
    logic       ack;
    logic       done;
    logic       req;
    logic [1:0] layer;
    logic [2:0] hold;
    logic       busy;
    logic [2:0] pend;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic do_reset3();
    resn = 1'b0;
    rd3.readout_ack = 1'b0;
    rd3.readout_done = 1'b0;
    tick();
    resn = 1'b1;
  endtask

  task automatic wait_req3(input string tag);
    int n;
    n = 0;
    while (rd3.readout_req !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    check($sformatf("%s req", tag), 32'(rd3.readout_req), 32'd1);
  endtask

  task automatic grant3(input logic [1:0] exp_layer, input string tag);
    logic [2:0] one;
    one = 3'b001;
    wait_req3(tag);
    check($sformatf("%s layer", tag), 32'(rd3.readout_layer), 32'(exp_layer));
    check($sformatf("%s hold before ack", tag), 32'(hold3), 32'd0);
    rd3.readout_ack = 1'b1;
    tick();
    rd3.readout_ack = 1'b0;
    check($sformatf("%s hold", tag), 32'(hold3), 32'(one << exp_layer));
    check($sformatf("%s req dropped", tag), 32'(rd3.readout_req), 32'd0);
  endtask

  task automatic serve3(input logic [1:0] exp_layer, input string tag);
    grant3(exp_layer, tag);
    tick();
    rd3.readout_done = 1'b1;
    tick();
    rd3.readout_done = 1'b0;
    check($sformatf("%s hold released", tag), 32'(hold3), 32'd0);
    check($sformatf("%s busy in holdoff", tag), 32'(busy3), 32'd1);
  endtask

  function automatic logic aux_req(input int w);
    return (w == 5) ? rd5.readout_req : rd1.readout_req;
  endfunction

  function automatic logic [31:0] aux_layer(input int w);
    return (w == 5) ? 32'(rd5.readout_layer) : 32'(rd1.readout_layer);
  endfunction

  function automatic logic [31:0] aux_hold(input int w);
    return (w == 5) ? 32'(hold5) : 32'(hold1);
  endfunction

  task automatic set_aux(input int w, input logic ack, input logic done);
    if (w == 5) begin
      rd5.readout_ack = ack;
      rd5.readout_done = done;
    end else begin
      rd1.readout_ack = ack;
      rd1.readout_done = done;
    end
  endtask

  task automatic grant_aux(input int w, input int exp_layer, input string tag);
    int n;
    n = 0;
    while (aux_req(w) !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    check($sformatf("%s req", tag), 32'(aux_req(w)), 32'd1);
    check($sformatf("%s layer", tag), aux_layer(w), 32'(exp_layer));
    set_aux(w, 1'b1, 1'b0);
    tick();
    set_aux(w, 1'b0, 1'b0);
    check($sformatf("%s hold", tag), aux_hold(w), 32'd1 << exp_layer);
  endtask

  task automatic done_aux(input int w, input string tag);
    tick();
    set_aux(w, 1'b0, 1'b1);
    tick();
    set_aux(w, 1'b0, 1'b0);
    check($sformatf("%s hold released", tag), aux_hold(w), 32'd0);
  endtask

  task automatic aux_reset_check(input int w, input string tag);
    if (w == 5) resn5 = 1'b0; else resn1 = 1'b0;
    tick();
    check($sformatf("%s req", tag), 32'(aux_req(w)), 32'd0);
    check($sformatf("%s layer", tag), aux_layer(w), 32'd0);
    check($sformatf("%s hold", tag), aux_hold(w), 32'd0);
    check($sformatf("%s busy", tag), (w == 5) ? 32'(busy5) : 32'(busy1), 32'd0);
    check($sformatf("%s pending", tag), (w == 5) ? 32'(pend5) : 32'(pend1), 32'd0);
    if (w == 5) resn5 = 1'b1; else resn1 = 1'b1;
  endtask

  initial begin
    logic [1:0] exp2 [6];
    logic [1:0] exp3 [4];
    int         bad;
    int         early;

    n_checks = 0;
    n_fail   = 0;
    resn = 1'b0; resn5 = 1'b0; resn1 = 1'b0;
    intn3 = '1; en3 = '1; intn5 = '1; en5 = '1; intn1 = '1; en1 = '1;
    rd3.readout_ack = 1'b0; rd3.readout_done = 1'b0;
    rd5.readout_ack = 1'b0; rd5.readout_done = 1'b0;
    rd1.readout_ack = 1'b0; rd1.readout_done = 1'b0;

    //            resn  intn    ack   done  req   layer hold    busy  pend
    vecs[0]  = '{1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 2'd0, 3'b000, 1'b0, 3'b000};
    vecs[1]  = '{1'b1, 3'b101, 1'b0, 1'b0, 1'b0, 2'd0, 3'b000, 1'b0, 3'b000};
    vecs[2]  = '{1'b1, 3'b101, 1'b0, 1'b0, 1'b0, 2'd0, 3'b000, 1'b0, 3'b010};
    vecs[3]  = '{1'b1, 3'b101, 1'b0, 1'b0, 1'b1, 2'd1, 3'b000, 1'b1, 3'b010};
    vecs[4]  = '{1'b1, 3'b101, 1'b0, 1'b0, 1'b1, 2'd1, 3'b000, 1'b1, 3'b010};
    vecs[5]  = '{1'b1, 3'b101, 1'b1, 1'b0, 1'b0, 2'd1, 3'b010, 1'b1, 3'b010};
    vecs[6]  = '{1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 2'd1, 3'b010, 1'b1, 3'b010};
    vecs[7]  = '{1'b1, 3'b111, 1'b0, 1'b1, 1'b0, 2'd1, 3'b000, 1'b1, 3'b000};
    vecs[8]  = '{1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 2'd1, 3'b000, 1'b1, 3'b000};
    vecs[9]  = '{1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 2'd1, 3'b000, 1'b1, 3'b000};
    vecs[10] = '{1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 2'd1, 3'b000, 1'b1, 3'b000};
    vecs[11] = '{1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 2'd1, 3'b000, 1'b0, 3'b000};
    vecs[12] = '{1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 2'd1, 3'b000, 1'b0, 3'b000};

    exp2 = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    exp3 = '{2'd0, 2'd2, 2'd0, 2'd2};

    // Reset, single-layer grant, ack, done and holdoff, one edge per row.
    for (int i = 0; i < 13; i++) begin
      resn             = vecs[i].resn;
      intn3            = vecs[i].intn;
      rd3.readout_ack  = vecs[i].ack;
      rd3.readout_done = vecs[i].done;
      tick();
      check($sformatf("t1[%0d] req", i),   32'(rd3.readout_req),   32'(vecs[i].req));
      check($sformatf("t1[%0d] layer", i), 32'(rd3.readout_layer), 32'(vecs[i].layer));
      check($sformatf("t1[%0d] hold", i),  32'(hold3),             32'(vecs[i].hold));
      check($sformatf("t1[%0d] busy", i),  32'(busy3),             32'(vecs[i].busy));
      check($sformatf("t1[%0d] pend", i),  32'(pend3),             32'(vecs[i].pend));
      check($sformatf("t1[%0d] abort", i), 32'(abort3),            32'd0);
      check($sformatf("t1[%0d] tcnt", i),  32'(tcnt3),             32'd0);
    end
    rd3.readout_ack = 1'b0;
    rd3.readout_done = 1'b0;

    // All layers pending: strict round-robin.
    do_reset3();
    intn3 = 3'b000;
    for (int i = 0; i < 6; i++) serve3(exp2[i], $sformatf("t2 grant%0d", i));

    // Layer 1 masked off.
    do_reset3();
    en3 = 3'b101;
    intn3 = 3'b000;
    for (int i = 0; i < 4; i++) begin
      serve3(exp3[i], $sformatf("t3 grant%0d", i));
      check($sformatf("t3 pend%0d", i), 32'(pend3), 32'h5);
    end
    en3 = 3'b111;

    // Interrupt released and mask cleared while the request is outstanding.
    do_reset3();
    intn3 = 3'b011;
    wait_req3("t5");
    check("t5 layer", 32'(rd3.readout_layer), 32'd2);
    intn3 = 3'b111;
    en3 = 3'b000;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rd3.readout_req !== 1'b1 || rd3.readout_layer !== 2'd2) bad++;
    end
    check("t5 req held", 32'(bad), 32'd0);
    check("t5 pend masked", 32'(pend3), 32'd0);
    rd3.readout_ack = 1'b1;
    tick();
    rd3.readout_ack = 1'b0;
    check("t5 hold", 32'(hold3), 32'h4);
    tick();
    rd3.readout_done = 1'b1;
    tick();
    rd3.readout_done = 1'b0;
    check("t5 hold released", 32'(hold3), 32'd0);
    repeat (8) tick();
    check("t5 idle busy", 32'(busy3), 32'd0);
    check("t5 idle req", 32'(rd3.readout_req), 32'd0);
    en3 = 3'b111;

    // Timeout abort on the 4096th ACTIVE edge, then done racing the same edge.
    do_reset3();
    intn3 = 3'b110;
    grant3(2'd0, "t4a");
    early = 0;
    for (int i = 0; i < 4095; i++) begin
      tick();
      if (abort3 !== 1'b0) early++;
    end
    check("t4a no early abort", 32'(early), 32'd0);
    check("t4a hold before timeout", 32'(hold3), 32'h1);
    tick();
    check("t4a abort", 32'(abort3), 32'd1);
    check("t4a tcnt", 32'(tcnt3), 32'd1);
    check("t4a hold cleared", 32'(hold3), 32'd0);
    tick();
    check("t4a abort pulse", 32'(abort3), 32'd0);
    grant3(2'd0, "t4b");
    for (int i = 0; i < 4095; i++) tick();
    rd3.readout_done = 1'b1;
    tick();
    rd3.readout_done = 1'b0;
    check("t4b done wins abort", 32'(abort3), 32'd0);
    check("t4b tcnt", 32'(tcnt3), 32'd1);
    check("t4b hold", 32'(hold3), 32'd0);

    // Reset in ACTIVE clears everything, then layer 0 is granted first.
    intn3 = 3'b000;
    grant3(2'd1, "t6 pre");
    resn = 1'b0;
    tick();
    check("t6 rst req",   32'(rd3.readout_req),   32'd0);
    check("t6 rst layer", 32'(rd3.readout_layer), 32'd0);
    check("t6 rst hold",  32'(hold3),             32'd0);
    check("t6 rst busy",  32'(busy3),             32'd0);
    check("t6 rst abort", 32'(abort3),            32'd0);
    check("t6 rst tcnt",  32'(tcnt3),             32'd0);
    check("t6 rst pend",  32'(pend3),             32'd0);
    resn = 1'b1;
    serve3(2'd0, "t6 post");

    // Five layers: round-robin wraps 4 -> 0.
    resn5 = 1'b1;
    intn5 = 5'b00000;
    for (int i = 0; i < 6; i++) begin
      grant_aux(5, i % 5, $sformatf("t6 l5 grant%0d", i));
      done_aux(5, $sformatf("t6 l5 done%0d", i));
    end
    grant_aux(5, 1, "t6 l5 pre");
    aux_reset_check(5, "t6 l5 rst");
    grant_aux(5, 0, "t6 l5 post");
    done_aux(5, "t6 l5 post done");

    // Single layer: index is always 0.
    resn1 = 1'b1;
    intn1 = 1'b0;
    grant_aux(1, 0, "t6 l1 grant0");
    done_aux(1, "t6 l1 done0");
    grant_aux(1, 0, "t6 l1 grant1");
    aux_reset_check(1, "t6 l1 rst");
    grant_aux(1, 0, "t6 l1 post");
    done_aux(1, "t6 l1 post done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
